huffman_bit_packer: RTL and testbench
=====================================

# huffman_bit_packer

Parametrised bit packer for the Huffman datapath: accepts one variable-length code per handshake and packs the codes MSB-first into fixed `OUT_W`-bit words with valid/ready backpressure. A flush request emits the final partial word, zero-padded, with its valid-bit count. It sits directly behind the Huffman coder and replaces the raw code and length pins with a dense byte stream.

## Interface
- `MAX_LEN`, 10: maximum code length in bits; must be at least 1.
- `OUT_W`, 8: output word width; must be at least 2.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `in_len`.
- `CNT_W`, `$clog2(OUT_W+1)`: width of `out_bits`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: code present.
- `in_ready` out 1: packer accepts a code this cycle.
- `in_code` in MAX_LEN: code, right-aligned. Bit `in_len-1` is transmitted first. Bits at and above `in_len` are ignored (masked).
- `in_len` in LEN_W: code length, 0..MAX_LEN.
- `flush` in 1: one-cycle request to emit the remaining bits.
- `out_valid` out 1: word present.
- `out_ready` in 1: sink accepts the word.
- `out_data` out OUT_W: packed word; the oldest bit is in the MSB.
- `out_bits` out CNT_W: number of meaningful bits in `out_data`. Equals OUT_W except on the final flushed word.
- `out_last` out 1: final word of a flush.
- `flush_done` out 1: one-cycle pulse when a flush completes.
- `err` out 1: sticky; set when a code with `in_len > MAX_LEN` is dropped. Cleared only by reset.

## Operation
- Storage:
  - Accumulator `acc` of `ACC_W = OUT_W+MAX_LEN-1` bits, left-aligned, so the oldest bit is `acc[ACC_W-1]`.
  - Fill counter `cnt`, 0..ACC_W.
  - `flush_pend` flag.
- FSM states: ACCUM, DRAIN, FLUSH.
- ACCUM:
  - `in_ready = !flush_pend`.
  - On `in_valid && in_ready` with `in_len <= MAX_LEN`: the masked code is written at `acc[ACC_W-1-cnt -: in_len]`, and `cnt += in_len`.
  - `in_len == 0` is accepted as a no-op.
  - `in_len > MAX_LEN`: the handshake completes, `acc` and `cnt` are unchanged, and `err` is set.
  - Next state:
    - DRAIN if the new `cnt >= OUT_W`.
    - Otherwise FLUSH if `flush_pend` is set, or `flush` is high this cycle.
    - Otherwise ACCUM.
- DRAIN:
  - `out_valid=1`, `out_data = acc[ACC_W-1 -: OUT_W]`, `out_bits=OUT_W`, `out_last=0`.
  - On `out_ready`: `acc <<= OUT_W`, `cnt -= OUT_W`.
  - After the pop: stay in DRAIN while `cnt >= OUT_W`, go to FLUSH if `flush_pend`, otherwise go to ACCUM.
- FLUSH:
  - `cnt == 0`: no word is produced; pulse `flush_done`, clear `flush_pend`, go to ACCUM.
  - Otherwise: `out_valid=1`, `out_data` is the top OUT_W bits with zeros below `cnt`, `out_bits=cnt`, `out_last=1`.
  - On `out_ready`: clear `acc`, `cnt` and `flush_pend`, pulse `flush_done`, go to ACCUM.
- Boundary rules:
  - `flush` high in DRAIN or FLUSH sets `flush_pend`; it is serviced after the current drain.
  - `flush` together with an accepted code: the code is included in the flushed data.
  - `flush` while `flush_pend` is already set is absorbed.
  - Overflow cannot occur: codes are accepted only when `cnt < OUT_W`, so `cnt <= ACC_W`.
  - Input acceptance and output pop never happen in the same cycle.

## Timing
- Reset values (asynchronous, applied immediately when `rst_n` goes low):
  - State ACCUM.
  - `acc=0`, `cnt=0`, `flush_pend=0`.
  - `in_ready=1`, `out_valid=0`, `out_data=0`, `out_bits=0`, `out_last=0`, `flush_done=0`, `err=0`.
- Reset mid-DRAIN or mid-FLUSH discards all buffered bits; no word is emitted after release.
- All outputs come from registers or from the state and `flush_pend` decode; there is no combinational path from `out_ready` or `in_valid`.
- Latency: a code accepted at edge N that completes a word gives `out_valid` high in cycle N+1.
- `out_data`, `out_bits` and `out_last` are stable while `out_valid && !out_ready`.
- Throughput: one code per cycle while no word is pending; each full word costs at least one cycle.
- `flush_done` is high for exactly one cycle.

## Structure
- Shared package `huffman_pkg`:
  - `HUFF_MAX_LEN` default (10) and `HUFF_OUT_W` default (8).
  - `packer_state_t` enum (ACCUM, DRAIN, FLUSH).
- No sub-module. The insert shift and mask are combinational inside the block.
- The top level instantiates this block after the Huffman coder, mapping `out_data` to `uo_out` and the handshake signals to `uio`.

## Test plan
(All scenarios use MAX_LEN=10, OUT_W=8.)
- Codes 3'b101 (len 3), then 5'b11000 (len 5) -> one word 8'hB8, `out_bits=8`, `out_last=0`, `out_valid` one cycle after the second accept.
- 10'h3FF (len 10), 10'h000 (len 10), then `flush` -> words 8'hFF, then 8'hC0, then 8'h00 with `out_bits=4`, `out_last=1`, and `flush_done` pulsed.
- `out_ready` held low for 5 cycles during DRAIN -> `out_data` constant, `in_ready=0`, no symbol lost, and the correct word stream after release.
- `flush` with `cnt=0` -> no `out_valid`, `flush_done` high for one cycle, next cycle `in_ready=1`.
- `in_len=11` -> handshake completes, `err=1` and stays set, `cnt` unchanged. `in_len=0` -> accepted, no output change.
- `rst_n` pulled low mid-DRAIN between clock edges -> `out_valid=0` and `cnt=0` immediately, and the stream restarts clean after release.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared Huffman datapath types and defaults.
// Holds packer default widths and the packer FSM state encoding.
package huffman_pkg;

  localparam int HUFF_MAX_LEN = 10;
  localparam int HUFF_OUT_W   = 8;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    FLUSH
  } packer_state_t;

endpackage

// File: rtl/huffman_bit_packer.sv
// Packs variable-length codes MSB-first into OUT_W-bit words.
// Ports: clk, rst_n; in_valid/in_ready/in_code/in_len code input;
//   flush request; out_valid/out_ready/out_data/out_bits/out_last
//   word output; flush_done pulse; err sticky bad-length flag.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = HUFF_MAX_LEN,
  parameter int OUT_W   = HUFF_OUT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = $clog2(OUT_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_code,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_bits,
  output logic               out_last,
  output logic               flush_done,
  output logic               err
);

  localparam int ACC_W = OUT_W + MAX_LEN - 1;
  localparam int AC_W  = $clog2(ACC_W + 1);

  localparam logic [AC_W-1:0]  OUT_WC   = AC_W'(OUT_W);
  localparam logic [AC_W-1:0]  ACC_WC   = AC_W'(ACC_W);
  localparam logic [LEN_W-1:0] MAX_LENC = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN:0] ONE      = 1;

  packer_state_t state, state_n;

  logic [ACC_W-1:0] acc, acc_n;
  logic [AC_W-1:0]  cnt, cnt_n;
  logic             flush_pend, pend_n;
  logic             err_q, err_n;
  logic             done_q, done_n;

  logic [MAX_LEN:0]   len_mask;
  logic [MAX_LEN-1:0] code_m;
  logic [AC_W-1:0]    ins_sh;
  logic [ACC_W-1:0]   ins;
  logic [AC_W-1:0]    cnt_in;
  logic [OUT_W-1:0]   top_word;
  logic [OUT_W-1:0]   tail_mask;
  logic               take;
  logic               bad_len;

  // Insert path: mask the code to in_len bits and drop it
  // just below the bits already held.
  always_comb begin
    len_mask = (ONE << in_len) - ONE;
    code_m   = in_code & len_mask[MAX_LEN-1:0];
    ins_sh   = ACC_WC - cnt - AC_W'(in_len);
    ins      = ACC_W'(code_m) << ins_sh;
    cnt_in   = cnt + AC_W'(in_len);
    bad_len  = in_len > MAX_LENC;
  end

  assign in_ready = (state == ACCUM) && !flush_pend;
  assign take     = in_valid && in_ready;

  assign top_word  = acc[ACC_W-1 -: OUT_W];
  assign tail_mask = ~({OUT_W{1'b1}} >> cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      flush_pend <= pend_n;
      err_q      <= err_n;
      done_q     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    pend_n  = flush_pend | flush;
    err_n   = err_q;
    done_n  = 1'b0;
    unique case (state)
      ACCUM: begin
        if (take) begin
          if (bad_len) begin
            err_n = 1'b1;
          end else begin
            acc_n = acc | ins;
            cnt_n = cnt_in;
          end
        end
        if (cnt_n >= OUT_WC) begin
          state_n = DRAIN;
        end else if (flush_pend || flush) begin
          state_n = FLUSH;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          acc_n = acc << OUT_W;
          cnt_n = cnt - OUT_WC;
          if (cnt_n >= OUT_WC) begin
            state_n = DRAIN;
          end else if (pend_n) begin
            state_n = FLUSH;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      FLUSH: begin
        // A flush arriving during completion is absorbed.
        if (cnt == '0 || out_ready) begin
          acc_n   = '0;
          cnt_n   = '0;
          pend_n  = 1'b0;
          done_n  = 1'b1;
          state_n = ACCUM;
        end
      end
      default: begin
        state_n = ACCUM;
      end
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_bits  = '0;
    out_last  = 1'b0;
    unique case (1'b1)
      (state == DRAIN): begin
        out_valid = 1'b1;
        out_data  = top_word;
        out_bits  = CNT_W'(OUT_W);
      end
      (state == FLUSH && cnt != '0): begin
        out_valid = 1'b1;
        out_data  = top_word & tail_mask;
        out_bits  = CNT_W'(cnt);
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign flush_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench for huffman_bit_packer (MAX_LEN=10, OUT_W=8).
// Directed scenarios plus a randomized run against a bit-queue model.
module tb_huffman_bit_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_code;
  logic [3:0] in_len;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_bits;
  logic       out_last;
  logic       flush_done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  huffman_bit_packer #(
    .MAX_LEN(10),
    .OUT_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_len    (in_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .flush_done(flush_done),
    .err       (err)
  );

  task automatic send(input logic [9:0] c, input logic [3:0] l);
    in_code  = c;
    in_len   = l;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_code = 0; in_len = 0;
    flush = 0; out_ready = 0;
    #12;
    vectors++;
    if ({in_ready, out_valid, out_data, out_bits, out_last, flush_done, err}
        !== {1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h b=%0d l=%b fd=%b e=%b",
        in_ready, out_valid, out_data, out_bits, out_last, flush_done, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic_word();
    send(10'b101, 3);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid got %b want 0", out_valid);
    end
    send(10'b11000, 5);
    vectors++;
    if ({out_valid, out_data, out_bits, out_last, in_ready}
        !== {1'b1, 8'hB8, 4'd8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_word got v=%b d=%h b=%0d l=%b rdy=%b want 1 b8 8 0 0",
        out_valid, out_data, out_bits, out_last, in_ready);
    end
    pop();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after_pop got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush_sequence();
    send(10'h3FF, 10);
    vectors++;
    if ({out_valid, out_data, out_bits} !== {1'b1, 8'hFF, 4'd8}) begin
      miscompares++;
      $display("FAIL flushseq_w0 got v=%b d=%h b=%0d want 1 ff 8",
        out_valid, out_data, out_bits);
    end
    pop();
    in_code = 10'h000; in_len = 10; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    vectors++;
    if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 8'hC0, 4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL flushseq_w1 got v=%b d=%h b=%0d l=%b want 1 c0 8 0",
        out_valid, out_data, out_bits, out_last);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out_data, out_bits, out_last, flush_done}
        !== {1'b1, 8'h00, 4'd4, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL flushseq_last got v=%b d=%h b=%0d l=%b fd=%b want 1 00 4 1 0",
        out_valid, out_data, out_bits, out_last, flush_done);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({flush_done, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL flushseq_done got fd=%b v=%b want 1 0", flush_done, out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (flush_done !== 1'b0) begin
      miscompares++;
      $display("FAIL flushseq_done_width got %b want 0", flush_done);
    end
  endtask

  task automatic test_backpressure();
    send(10'h0A5, 8);
    in_code = 10'h03C; in_len = 8; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 8'hA5, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold got v=%b d=%h rdy=%b want 1 a5 0",
          out_valid, out_data, in_ready);
      end
    end
    pop();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin
      miscompares++;
      $display("FAIL stall_next_word got v=%b d=%h want 1 3c", out_valid, out_data);
    end
    pop();
  endtask

  task automatic test_empty_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if ({out_valid, flush_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL eflush_first got v=%b fd=%b want 0 0", out_valid, flush_done);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, flush_done, in_ready} !== 3'b011) begin
      miscompares++;
      $display("FAIL eflush_done got v=%b fd=%b rdy=%b want 0 1 1",
        out_valid, flush_done, in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, flush_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL eflush_after got v=%b fd=%b want 0 0", out_valid, flush_done);
    end
  endtask

  task automatic test_err_len();
    send(10'b011, 3);
    send(10'h3FF, 11);
    vectors++;
    if ({err, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_set got e=%b v=%b want 1 0", err, out_valid);
    end
    send(10'h3FF, 0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len got v=%b want 0", out_valid);
    end
    send(10'b10101, 5);
    vectors++;
    if ({out_valid, out_data, err} !== {1'b1, 8'h75, 1'b1}) begin
      miscompares++;
      $display("FAIL err_cnt_kept got v=%b d=%h e=%b want 1 75 1",
        out_valid, out_data, err);
    end
    pop();
  endtask

  task automatic test_reset_mid_drain();
    send(10'h3FF, 10);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, out_bits, out_data, err}
        !== {1'b0, 1'b1, 4'd0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got v=%b rdy=%b b=%0d d=%h e=%b want 0 1 0 00 0",
        out_valid, in_ready, out_bits, out_data, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_word got v=%b want 0", out_valid);
    end
    send(10'h00F, 8);
    vectors++;
    if ({out_valid, out_data, out_bits} !== {1'b1, 8'h0F, 4'd8}) begin
      miscompares++;
      $display("FAIL reset_clean got v=%b d=%h b=%0d want 1 0f 8",
        out_valid, out_data, out_bits);
    end
    pop();
  endtask

  task automatic test_random();
    bit         bq[$];
    logic       exp_err;
    logic       stall_prev;
    logic       done_prev;
    logic [7:0] pd;
    logic [3:0] pb;
    logic       pl;
    logic [7:0] ed;
    int         n;
    int         nrun;
    nrun = 3000;
    rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 0;
    #7; rst_n = 1'b1;
    exp_err = 1'b0; stall_prev = 1'b0; done_prev = 1'b0;
    pd = '0; pb = '0; pl = 1'b0;
    for (int t = 0; t < nrun; t++) begin
      @(negedge clk);
      if (t < nrun - 40) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_code   = 10'($urandom);
        in_len    = ($urandom_range(0, 19) == 0) ?
                    4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
        flush     = ($urandom_range(0, 24) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = (t == nrun - 30);
      end
      vectors++;
      if (err !== exp_err) begin
        miscompares++;
        $display("FAIL rnd_err t=%0d got %b want %b", t, err, exp_err);
      end
      if (stall_prev) begin
        vectors++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, pd, pb, pl}) begin
          miscompares++;
          $display("FAIL rnd_stable t=%0d got v=%b d=%h b=%0d l=%b want 1 %h %0d %b",
            t, out_valid, out_data, out_bits, out_last, pd, pb, pl);
        end
      end
      if (flush_done) begin
        vectors++;
        if (bq.size() != 0 || done_prev) begin
          miscompares++;
          $display("FAIL rnd_flush_done t=%0d pending_bits %0d prev_done %b want 0 0",
            t, bq.size(), done_prev);
        end
      end
      if (out_valid && out_ready) begin
        n  = (bq.size() < 8) ? bq.size() : 8;
        ed = '0;
        for (int i = 0; i < n; i++) ed[7-i] = bq[i];
        vectors++;
        if ({out_data, out_bits, out_last} !== {ed, 4'(n), (bq.size() < 8)}) begin
          miscompares++;
          $display("FAIL rnd_word t=%0d got d=%h b=%0d l=%b want %h %0d %b",
            t, out_data, out_bits, out_last, ed, n, (bq.size() < 8));
        end
        repeat (n) void'(bq.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_len > 10) begin
          exp_err = 1'b1;
        end else begin
          for (int i = int'(in_len) - 1; i >= 0; i--) bq.push_back(in_code[i]);
        end
      end
      stall_prev = out_valid && !out_ready;
      pd = out_data; pb = out_bits; pl = out_last;
      done_prev = flush_done;
    end
    vectors++;
    if (bq.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_leftover got %0d bits want 0", bq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_flush_sequence();
    test_backpressure();
    test_empty_flush();
    test_err_len();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
